// File: rtl/fpu_sched_pkg.sv
// Shared types and constants for the add/sub datapath scheduler.
package fpu_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } sched_state_t;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } fp_op_t;

  localparam int unsigned SIGN_BIT = 31;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N  = 2,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          any
);

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!any && req[(32'(ptr) + i) % N]) begin
        any                        = 1'b1;
        gnt[(32'(ptr) + i) % N]    = 1'b1;
        gnt_idx                    = PW'((32'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/fpu_addsub_sched.sv
// Shares one single-precision add/sub datapath between NREQ requesters,
// holding operands for DP_LAT cycles and returning the result to the owner.
module fpu_addsub_sched
  import fpu_sched_pkg::*;
#(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned DP_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ-1:0]    req_op,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  output logic [NREQ-1:0]    resp_valid,
  input  logic [NREQ-1:0]    resp_ready,
  output logic [31:0]        resp_result,
  output logic [31:0]        dp_data1,
  output logic [31:0]        dp_data2,
  input  logic [31:0]        dp_result,
  output logic               busy
);

  localparam int unsigned PW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(DP_LAT + 1);

  sched_state_t    state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [31:0]     opa_q, opa_d;
  logic [31:0]     opb_q, opb_d;
  logic [31:0]     res_q, res_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [NREQ-1:0] gnt;
  logic [PW-1:0]   gnt_idx;
  logic            arb_any;
  logic [31:0]     sel_a, sel_b;
  logic            sel_op;

  rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (arb_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    sel_a   = '0;
    sel_b   = '0;
    sel_op  = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_a  = req_a[i*32 +: 32];
        sel_b  = req_b[i*32 +: 32];
        sel_op = req_op[i];
      end
    end
    unique case (state_q)
      IDLE: begin
        // In IDLE a grant is the handshake: req_ready mirrors gnt.
        if (arb_any) begin
          opa_d = sel_a;
          opb_d = sel_b;
          if (fp_op_t'(sel_op) == OP_SUB) opb_d[SIGN_BIT] = ~sel_b[SIGN_BIT];
          owner_d = gnt_idx;
          cnt_d   = '0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(DP_LAT - 1)) begin
          res_d   = dp_result;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready[owner_q]) begin
          state_d = IDLE;
          ptr_d   = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    // Gated by rst so no grant is advertised while reset is held.
    req_ready  = (state_q == IDLE && !rst) ? gnt : '0;
    resp_valid = '0;
    if (state_q == RESP) resp_valid[owner_q] = 1'b1;
    resp_result = res_q;
    dp_data1    = opa_q;
    dp_data2    = opb_q;
    busy        = (state_q != IDLE);
  end

endmodule
